// File: rtl/dms_lpf2_trim_cal.sv
// -----------------------------------------------------------------------------
// dms_lpf2_trim_cal
//   Successive-approximation calibration of the 4-bit pole trim of the
//   second-order low-pass filter in the DMS chain. Each trial discharges the
//   filter, applies a step, samples a threshold comparator and resolves one
//   trim bit MSB-first. The resolved code is held on trim until the next
//   calibration. A manual override can replace it at any time.
//
// Parameters
//   SETTLE_CYC   : cycles with stimulus low before each trial (1..1023)
//   MEAS_CYC     : cycles with stimulus high before sampling cmp (1..1023)
//   TRIM_DEFAULT : trim after reset and after an aborted calibration
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   cal_start    : level request, honoured only in IDLE without override
//   cmp          : comparator, 1 = filter output above threshold (too fast)
//   trim_ovr_en  : manual override enable (aborts a running calibration)
//   trim_ovr     : manual trim value
//   trim         : trim code driven to the filter
//   stim_en      : step stimulus enable
//   cal_busy     : high in DISCH, STEP and DECIDE
//   cal_done     : one-cycle pulse when a calibration completes
//   cal_err      : sticky error status of the last completed calibration
// -----------------------------------------------------------------------------
module dms_lpf2_trim_cal #(
  parameter int unsigned SETTLE_CYC   = 64,
  parameter int unsigned MEAS_CYC     = 16,
  parameter logic [3:0]  TRIM_DEFAULT = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cal_start,
  input  logic       cmp,
  input  logic       trim_ovr_en,
  input  logic [3:0] trim_ovr,
  output logic [3:0] trim,
  output logic       stim_en,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DISCH  = 3'd1,
    STEP   = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // The counter is loaded with N-1 on entry so the state lasts N cycles.
  localparam logic [9:0] SETTLE_LOAD = 10'(SETTLE_CYC - 1);
  localparam logic [9:0] MEAS_LOAD   = 10'(MEAS_CYC - 1);

  state_t     state_reg,   state_next;
  logic [9:0] cnt_reg,     cnt_next;
  logic [1:0] bit_idx_reg, bit_idx_next;
  logic [3:0] code_reg,    code_next;
  logic [3:0] result_reg,  result_next;
  logic       cmp_smp_reg, cmp_smp_next;
  logic       x_seen_reg,  x_seen_next;
  logic [3:0] trim_reg,    trim_next;
  logic       stim_reg,    stim_next;
  logic       busy_reg,    busy_next;
  logic       done_reg,    done_next;
  logic       err_reg,     err_next;

  // An unknown comparator level is a calibration fault: it is flagged and
  // resolved pessimistically as "too fast" (1). In silicon both compares
  // are constant and this collapses to a plain wire.
  logic cmp_is_x;
  logic cmp_eff;
  assign cmp_is_x = (cmp !== 1'b0) && (cmp !== 1'b1);
  assign cmp_eff  = cmp_is_x || (cmp === 1'b1);

  // Per-bit trial update: code_decided clears the bit under test when the
  // sampled comparator said "too fast"; code_advanced additionally sets the
  // next lower bit as the following trial guess.
  logic [3:0] code_decided;
  logic [3:0] code_advanced;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sar_bit
      assign code_decided[gi]  = code_reg[gi] &
                                 ~(cmp_smp_reg && (bit_idx_reg == 2'(gi)));
      assign code_advanced[gi] = code_decided[gi] |
                                 ((bit_idx_reg != 2'd0) &&
                                  ((bit_idx_reg - 2'd1) == 2'(gi)));
    end
  endgenerate

  logic abort;
  assign abort = trim_ovr_en &&
                 ((state_reg == DISCH) || (state_reg == STEP) ||
                  (state_reg == DECIDE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= 2'd3;
      code_reg    <= TRIM_DEFAULT;
      result_reg  <= TRIM_DEFAULT;
      cmp_smp_reg <= 1'b0;
      x_seen_reg  <= 1'b0;
      trim_reg    <= TRIM_DEFAULT;
      stim_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      code_reg    <= code_next;
      result_reg  <= result_next;
      cmp_smp_reg <= cmp_smp_next;
      x_seen_reg  <= x_seen_next;
      trim_reg    <= trim_next;
      stim_reg    <= stim_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    code_next    = code_reg;
    result_next  = result_reg;
    cmp_smp_next = cmp_smp_reg;
    x_seen_next  = x_seen_reg;
    trim_next    = trim_reg;
    stim_next    = stim_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = err_reg;

    if (abort) begin
      // Override wins mid-calibration: drop the partial result, no done
      // pulse, error status left as it is.
      state_next  = IDLE;
      cnt_next    = '0;
      result_next = TRIM_DEFAULT;
      trim_next   = trim_ovr;
      stim_next   = 1'b0;
      busy_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          trim_next = trim_ovr_en ? trim_ovr : result_reg;
          if (cal_start && !trim_ovr_en) begin
            state_next   = DISCH;
            cnt_next     = SETTLE_LOAD;
            bit_idx_next = 2'd3;
            code_next    = 4'b1000;
            trim_next    = 4'b1000;
            x_seen_next  = 1'b0;
            err_next     = 1'b0;
            busy_next    = 1'b1;
            stim_next    = 1'b0;
          end
        end

        DISCH: begin
          if (cnt_reg == 10'd0) begin
            state_next = STEP;
            cnt_next   = MEAS_LOAD;
            stim_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg - 10'd1;
          end
        end

        STEP: begin
          if (cnt_reg == 10'd0) begin
            state_next   = DECIDE;
            cnt_next     = '0;
            stim_next    = 1'b0;
            cmp_smp_next = cmp_eff;
            x_seen_next  = x_seen_reg | cmp_is_x;
          end else begin
            cnt_next = cnt_reg - 10'd1;
          end
        end

        DECIDE: begin
          if (bit_idx_reg != 2'd0) begin
            state_next   = DISCH;
            cnt_next     = SETTLE_LOAD;
            bit_idx_next = bit_idx_reg - 2'd1;
            code_next    = code_advanced;
            trim_next    = code_advanced;
          end else begin
            // Last bit resolved: publish the code and its status together
            // with the done pulse.
            state_next  = DONE;
            cnt_next    = '0;
            code_next   = code_decided;
            trim_next   = code_decided;
            result_next = code_decided;
            busy_next   = 1'b0;
            done_next   = 1'b1;
            err_next    = (code_decided == 4'd0) || (code_decided == 4'd15) ||
                          x_seen_reg;
          end
        end

        DONE: begin
          state_next = IDLE;
          cnt_next   = '0;
          trim_next  = trim_ovr_en ? trim_ovr : result_reg;
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
          stim_next  = 1'b0;
        end
      endcase
    end
  end

  assign trim     = trim_reg;
  assign stim_en  = stim_reg;
  assign cal_busy = busy_reg;
  assign cal_done = done_reg;
  assign cal_err  = err_reg;

endmodule

// File: tb/tb_dms_lpf2_trim_cal.sv
// -----------------------------------------------------------------------------
// tb_dms_lpf2_trim_cal
//   Self-checking bench for dms_lpf2_trim_cal with SETTLE_CYC=4, MEAS_CYC=2.
//   The comparator is a bench model of the filter (cmp = trim >= threshold,
//   or tied low/high). Expected trial codes, final code and error flag come
//   from a plain-arithmetic SAR model; the cycle-by-cycle output shape is
//   derived from the trial length T = S + M + 1.
// -----------------------------------------------------------------------------
module tb_dms_lpf2_trim_cal;

  localparam int S = 4;
  localparam int M = 2;
  localparam int T = S + M + 1;

  localparam int MODE_THR  = 0;
  localparam int MODE_LOW  = 1;
  localparam int MODE_HIGH = 2;

  logic       clk;
  logic       rst;
  logic       cal_start;
  logic       cmp;
  logic       trim_ovr_en;
  logic [3:0] trim_ovr;
  logic [3:0] trim;
  logic       stim_en;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_err;

  bit         clk_run;
  int         n_checks;
  int         n_fail;

  logic [3:0] model_result;
  logic       model_err;
  logic [3:0] exp_trials [4];
  logic [3:0] exp_final;
  logic       exp_err;

  // Value delivered when the bench drives an unknown onto cmp. A two-state
  // simulator turns it into 0 or 1; the model follows whatever it became.
  logic       xdrv;
  bit         x_is_4state;

  dms_lpf2_trim_cal #(
    .SETTLE_CYC   (S),
    .MEAS_CYC     (M),
    .TRIM_DEFAULT (4'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cal_start   (cal_start),
    .cmp         (cmp),
    .trim_ovr_en (trim_ovr_en),
    .trim_ovr    (trim_ovr),
    .trim        (trim),
    .stim_en     (stim_en),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_err     (cal_err)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic oracle(input int mode, input int thr,
                                  input logic [3:0] code);
    case (mode)
      MODE_LOW:  return 1'b0;
      MODE_HIGH: return 1'b1;
      default:   return (int'(code) >= thr);
    endcase
  endfunction

  // Binary search for the trim: try each weight from 8 down to 1 on top of
  // the bits kept so far, keep it when the comparator says "not too fast".
  task automatic sar_model(input int mode, input int thr, input int xbit);
    int  kept;
    bit  any_x;
    logic c;
    kept  = 0;
    any_x = 0;
    for (int k = 3; k >= 0; k--) begin
      int guess;
      guess = kept + (1 << k);
      exp_trials[3-k] = 4'(guess);
      if (k == xbit) begin
        if (x_is_4state) begin
          c = 1'b1;
          any_x = 1;
        end else begin
          c = xdrv;
        end
      end else begin
        c = oracle(mode, thr, 4'(guess));
      end
      if (!c) kept = guess;
    end
    exp_final = 4'(kept);
    exp_err   = (kept == 0) || (kept == 15) || any_x;
  endtask

  // One full calibration, checked every cycle. Optional mid-run cal_start
  // pulse at cycle glitch_n must not disturb the sequence.
  task automatic run_cal(input int mode, input int thr, input int xbit,
                         input int glitch_n, input string name);
    sar_model(mode, thr, xbit);
    cal_start = 1'b1;
    cmp = oracle(mode, thr, trim);
    @(negedge clk);
    for (int n = 0; n <= 4*T + 1; n++) begin
      int t;
      int p;
      t = n / T;
      p = n % T;
      if (n < 4*T) begin
        check("trial_trim", trim, exp_trials[t]);
        check("trial_stim", stim_en, (p >= S) && (p < S + M));
        check("trial_busy", cal_busy, 1'b1);
        check("trial_done", cal_done, 1'b0);
        check("trial_err",  cal_err, 1'b0);
      end else if (n == 4*T) begin
        check("done_trim", trim, exp_final);
        check("done_stim", stim_en, 1'b0);
        check("done_busy", cal_busy, 1'b0);
        check("done_pulse", cal_done, 1'b1);
        check("done_err", cal_err, exp_err);
      end else begin
        check("idle_trim", trim, exp_final);
        check("idle_busy", cal_busy, 1'b0);
        check("idle_done", cal_done, 1'b0);
        check("idle_err", cal_err, exp_err);
      end
      if ((n < 4*T) && (p >= S) && (p < S + M) && ((3 - t) == xbit))
        cmp = xdrv;
      else
        cmp = oracle(mode, thr, trim);
      cal_start = (n == glitch_n);
      @(negedge clk);
    end
    model_result = exp_final;
    model_err    = exp_err;
    $display("cal %s mode=%0d thr=%0d xbit=%0d glitch=%0d -> trim=%0d err=%0d",
             name, mode, thr, xbit, glitch_n, exp_final, exp_err);
  endtask

  // Override in IDLE: follows trim_ovr one cycle later, blocks cal_start,
  // and releasing it restores the held result.
  task automatic run_ovr();
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    trim_ovr_en = 1'b1;
    trim_ovr    = v;
    cal_start   = 1'b1;
    @(negedge clk);
    check("ovr_trim", trim, v);
    check("ovr_busy", cal_busy, 1'b0);
    @(negedge clk);
    check("ovr_block", cal_busy, 1'b0);
    cal_start   = 1'b0;
    trim_ovr_en = 1'b0;
    @(negedge clk);
    check("ovr_release", trim, model_result);
    $display("ovr value=%0d release trim=%0d", v, model_result);
  endtask

  // Override raised in the second STEP aborts the calibration.
  task automatic run_abort();
    cal_start = 1'b1;
    cmp = oracle(MODE_THR, 5, trim);
    @(negedge clk);
    cal_start = 1'b0;
    for (int n = 0; n < T + S; n++) begin
      cmp = oracle(MODE_THR, 5, trim);
      @(negedge clk);
    end
    check("abort_in_step", stim_en, 1'b1);
    check("abort_pre_trim", trim, 4'd4);
    trim_ovr_en = 1'b1;
    trim_ovr    = 4'd3;
    @(negedge clk);
    check("abort_busy", cal_busy, 1'b0);
    check("abort_stim", stim_en, 1'b0);
    check("abort_trim", trim, 4'd3);
    check("abort_done", cal_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_done", cal_done, 1'b0);
      check("abort_hold_busy", cal_busy, 1'b0);
    end
    trim_ovr_en = 1'b0;
    @(negedge clk);
    check("abort_release", trim, 4'd8);
    check("abort_err", cal_err, 1'b0);
    model_result = 4'd8;
    model_err    = 1'b0;
    $display("abort in second STEP -> trim=8 after release");
  endtask

  // Reset in the middle of a STEP must clear outputs with no clock edge.
  task automatic run_reset_mid();
    cal_start = 1'b1;
    cmp = 1'b0;
    @(negedge clk);
    cal_start = 1'b0;
    for (int n = 0; n < S; n++) @(negedge clk);
    check("rst_pre_step", stim_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_trim", trim, 4'd8);
    check("rst_mid_stim", stim_en, 1'b0);
    check("rst_mid_busy", cal_busy, 1'b0);
    check("rst_mid_done", cal_done, 1'b0);
    check("rst_mid_err", cal_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_result = 4'd8;
    model_err    = 1'b0;
    @(negedge clk);
    check("rst_after_trim", trim, 4'd8);
    check("rst_after_busy", cal_busy, 1'b0);
    $display("reset mid-STEP -> outputs at reset values");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    clk_run      = 0;
    rst          = 1'b0;
    cal_start    = 1'b0;
    cmp          = 1'b0;
    trim_ovr_en  = 1'b0;
    trim_ovr     = 4'd0;
    xdrv         = 1'bx;
    x_is_4state  = (xdrv !== 1'b0) && (xdrv !== 1'b1);
    model_result = 4'd8;
    model_err    = 1'b0;

    // Reset with the clock stopped.
    #1 rst = 1'b1;
    #1;
    check("reset_trim", trim, 4'd8);
    check("reset_stim", stim_en, 1'b0);
    check("reset_busy", cal_busy, 1'b0);
    check("reset_done", cal_done, 1'b0);
    check("reset_err",  cal_err, 1'b0);
    $display("reset with clock stopped -> trim=8");

    clk_run = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_cal(MODE_THR,  5, -1, -1, "thr5");
    run_cal(MODE_LOW,  0, -1, -1, "tied0");
    run_cal(MODE_HIGH, 0, -1, -1, "tied1");
    run_cal(MODE_THR,  5, -1, 10, "thr5_glitch");
    run_ovr();
    run_abort();
    run_ovr();
    run_cal(MODE_THR,  5,  2, -1, "thr5_xbit2");

    for (int i = 0; i < 6; i++) begin
      int thr;
      int g;
      thr = $urandom_range(0, 16);
      g   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4*T - 1) : -1;
      run_cal(MODE_THR, thr, -1, g, "random");
      if ($urandom_range(0, 1) == 1) run_ovr();
    end

    run_reset_mid();
    run_cal(MODE_THR, $urandom_range(1, 15), -1, -1, "after_reset");
    run_ovr();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
